// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life LED matrix scanner.
// Grid map: bit 63 is row 0 / col 0; each row is one byte, MSB first.
package gol_pkg;

    localparam int GRID_W = 64;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    // Row r occupies grid[63-8r -: 8].
    function automatic logic [COLS-1:0] grid_row(input logic [GRID_W-1:0] grid,
                                                 input logic [2:0]        r);
        logic [5:0] base;
        base = 6'd63 - {r, 3'b000};
        return grid[base -: COLS];
    endfunction

endpackage

// File: rtl/gol_scan_timer.sv
// Loadable down-counter shared by the dwell and blank phases of the row scan.
// o_done is high while the count sits at zero.
module gol_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/gol_matrix_scan.sv
// Double-buffered 8x8 LED row scanner for Game-of-Life generations; requests a new
// generation every FRAMES_PER_GEN frames. All matrix outputs are registered.
module gol_matrix_scan #(
    parameter int DWELL          = 1000,
    parameter int BLANK          = 16,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [gol_pkg::GRID_W-1:0] grid_in,
    input  logic                       grid_valid,
    output logic                       grid_ready,
    output logic                       gen_step,
    output logic [7:0]                 row_en,
    output logic [7:0]                 col_on,
    output logic                       frame_start
);

    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int BL_W  = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam int TMR_W = (DW_W > BL_W) ? DW_W : BL_W;
    localparam int FR_W  = $clog2(FRAMES_PER_GEN + 1);

    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [FR_W-1:0]  FR_LAST    = FR_W'(FRAMES_PER_GEN - 1);

    gol_pkg::scan_state_t r_state, w_state_next;

    logic [2:0]       r_row, w_row_next;
    logic [FR_W-1:0]  r_frame_cnt;
    logic [63:0]      r_pending, r_display, w_display_next;
    logic             r_pending_full;
    logic             r_gen_step, r_frame_start;
    logic [7:0]       r_row_en, r_col_on;

    logic             w_tmr_load, w_tmr_done;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_swap, w_boundary, w_accept;
    logic             w_gen_step_next, w_frame_start_next;
    logic [7:0]       w_row_en_next, w_col_on_next;

    assign w_accept   = grid_valid && !r_pending_full;
    assign grid_ready = !r_pending_full;

    gol_scan_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= gol_pkg::IDLE;
            r_row          <= '0;
            r_frame_cnt    <= '0;
            r_pending      <= '0;
            r_display      <= '0;
            r_pending_full <= 1'b0;
            r_gen_step     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_row_en       <= '0;
            r_col_on       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_row         <= w_row_next;
            r_display     <= w_display_next;
            // swap and accept are exclusive: one needs pending full, the other empty
            if (w_swap) begin
                r_pending_full <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= grid_in;
                r_pending_full <= 1'b1;
            end
            if (w_boundary) begin
                r_frame_cnt <= (r_frame_cnt == FR_LAST) ? '0 : r_frame_cnt + FR_W'(1);
            end
            r_gen_step    <= w_gen_step_next;
            r_frame_start <= w_frame_start_next;
            r_row_en      <= w_row_en_next;
            r_col_on      <= w_col_on_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_tmr_load   = 1'b0;
        w_tmr_val    = DWELL_LOAD;
        w_boundary   = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            gol_pkg::IDLE: begin
                if (r_pending_full) begin
                    w_state_next = gol_pkg::SHOW;
                    w_row_next   = '0;
                    w_tmr_load   = 1'b1;
                    w_swap       = 1'b1;
                end
            end
            gol_pkg::SHOW: begin
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                    if (BLANK > 0) begin
                        w_state_next = gol_pkg::BLANK;
                        w_tmr_val    = BLANK_LOAD;
                    end else begin
                        w_row_next = r_row + 3'd1;
                        w_boundary = (r_row == 3'd7);
                    end
                end
            end
            gol_pkg::BLANK: begin
                if (w_tmr_done) begin
                    w_state_next = gol_pkg::SHOW;
                    w_row_next   = r_row + 3'd1;
                    w_tmr_load   = 1'b1;
                    w_boundary   = (r_row == 3'd7);
                end
            end
            default: w_state_next = gol_pkg::IDLE;
        endcase
        // A word accepted in the boundary cycle is not yet in pending here.
        if (w_boundary) begin
            w_swap = r_pending_full;
        end
    end

    always_comb begin
        w_display_next     = w_swap ? r_pending : r_display;
        w_row_en_next      = '0;
        w_col_on_next      = '0;
        if (w_state_next == gol_pkg::SHOW) begin
            w_row_en_next = 8'b1 << w_row_next;
            w_col_on_next = gol_pkg::grid_row(w_display_next, w_row_next);
        end
        w_frame_start_next = w_boundary ||
                             (r_state == gol_pkg::IDLE && w_state_next == gol_pkg::SHOW);
        w_gen_step_next    = w_boundary && (r_frame_cnt == FR_LAST);
    end

    assign gen_step    = r_gen_step;
    assign frame_start = r_frame_start;
    assign row_en      = r_row_en;
    assign col_on      = r_col_on;

endmodule
